// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: MEM/WB writeback, long-latency result handshake
// and the shared regfile write outputs.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_fp;
  logic              pipe_stall;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              lu_fp;
  logic              rf_we_int;
  logic              rf_we_fp;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output pipe_we, pipe_rd, pipe_data, pipe_fp,
    output lu_valid, lu_rd, lu_data, lu_fp,
    input  pipe_stall, lu_ready,
    input  rf_we_int, rf_we_fp, rf_waddr, rf_wdata
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, pipe_fp,
    input  lu_valid, lu_rd, lu_data, lu_fp,
    output pipe_stall, lu_ready,
    output rf_we_int, rf_we_fp, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between MEM/WB writeback (priority) and a buffered
// long-latency result, forcing a one-cycle pipe stall after STARVE_MAX denied cycles.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rst_n,
  wb_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  localparam logic [7:0] CNT_MAX = 8'(STARVE_MAX);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt, cnt_inc;
  logic [ADDR_W-1:0] buf_rd;
  logic [DATA_W-1:0] buf_data;
  logic              buf_fp;

  logic              gnt_pipe_p0, gnt_buf_p0, cap_p0, waw_p0;
  logic              sel_fp_p0, we_int_p0, we_fp_p0;
  logic [ADDR_W-1:0] sel_rd_p0;
  logic [DATA_W-1:0] sel_data_p0;

  // Both handshake outputs come straight from the state register.
  assign bus.lu_ready   = (state == IDLE);
  assign bus.pipe_stall = (state == FORCE);

  // Stage p0: grant decision and write-port select
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gnt_pipe_p0 = 1'b0;
    gnt_buf_p0  = 1'b0;
    cap_p0      = 1'b0;
    cnt_inc     = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 8'd1;
    waw_p0      = bus.pipe_we && (bus.pipe_rd == buf_rd) && (bus.pipe_fp == buf_fp);
    case (state)
      IDLE: begin
        gnt_pipe_p0 = bus.pipe_we;
        if (bus.lu_valid) begin
          cap_p0    = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = 8'd0;
        end
      end
      WAIT: begin
        if (!bus.pipe_we) begin
          gnt_buf_p0 = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = 8'd0;
        end else begin
          gnt_pipe_p0 = 1'b1;
          // A younger pipe write to the same register makes the buffered result dead.
          if (waw_p0) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_MAX) state_nxt = FORCE;
          end
        end
      end
      FORCE: begin
        gnt_buf_p0 = 1'b1;
        state_nxt  = IDLE;
        cnt_nxt    = 8'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase

    sel_fp_p0   = gnt_buf_p0 ? buf_fp   : bus.pipe_fp;
    sel_rd_p0   = gnt_buf_p0 ? buf_rd   : bus.pipe_rd;
    sel_data_p0 = gnt_buf_p0 ? buf_data : bus.pipe_data;
    we_int_p0   = (gnt_pipe_p0 || gnt_buf_p0) && !sel_fp_p0 && (sel_rd_p0 != '0);
    we_fp_p0    = (gnt_pipe_p0 || gnt_buf_p0) && sel_fp_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Buffer contents are qualified by state, so they need no reset.
  always_ff @(posedge clk) begin
    if (cap_p0) begin
      buf_rd   <= bus.lu_rd;
      buf_data <= bus.lu_data;
      buf_fp   <= bus.lu_fp;
    end
  end

  // Stage p1: registered regfile write, all-zero when nothing is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we_int <= 1'b0;
      bus.rf_we_fp  <= 1'b0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
    end else begin
      bus.rf_we_int <= we_int_p0;
      bus.rf_we_fp  <= we_fp_p0;
      bus.rf_waddr  <= (we_int_p0 || we_fp_p0) ? sel_rd_p0   : '0;
      bus.rf_wdata  <= (we_int_p0 || we_fp_p0) ? sel_data_p0 : '0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (STARVE_MAX=4) with hand-written
// starvation and reset-during-FORCE sequences.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        pfp;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        lfp;
    logic        es;
    logic        er;
    logic        ewi;
    logic        ewf;
    logic [4:0]  ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input int pwe, input int prd, input int pdata, input int pfp,
                              input int lv, input int lrd, input int ldata, input int lfp,
                              input int es, input int er, input int ewi, input int ewf,
                              input int ea, input int ed);
    vec_t v;
    v.pwe = 1'(pwe);  v.prd = 5'(prd);  v.pdata = 32'(pdata); v.pfp = 1'(pfp);
    v.lv  = 1'(lv);   v.lrd = 5'(lrd);  v.ldata = 32'(ldata); v.lfp = 1'(lfp);
    v.es  = 1'(es);   v.er  = 1'(er);   v.ewi   = 1'(ewi);    v.ewf = 1'(ewf);
    v.ea  = 5'(ea);   v.ed  = 32'(ed);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int es, input int er, input int ewi,
                         input int ewf, input int ea, input int ed);
    chk({tag, ".pipe_stall"}, 32'(bus.pipe_stall), 32'(es));
    chk({tag, ".lu_ready"},   32'(bus.lu_ready),   32'(er));
    chk({tag, ".rf_we_int"},  32'(bus.rf_we_int),  32'(ewi));
    chk({tag, ".rf_we_fp"},   32'(bus.rf_we_fp),   32'(ewf));
    chk({tag, ".rf_waddr"},   32'(bus.rf_waddr),   32'(ea));
    chk({tag, ".rf_wdata"},   bus.rf_wdata,        32'(ed));
  endtask

  task automatic drive(input int pwe, input int prd, input int pdata, input int pfp,
                       input int lv, input int lrd, input int ldata, input int lfp);
    bus.pipe_we   = 1'(pwe);
    bus.pipe_rd   = 5'(prd);
    bus.pipe_data = 32'(pdata);
    bus.pipe_fp   = 1'(pfp);
    bus.lu_valid  = 1'(lv);
    bus.lu_rd     = 5'(lrd);
    bus.lu_data   = 32'(ldata);
    bus.lu_fp     = 1'(lfp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                pwe prd pdata  pfp  lv lrd ldata  lfp   stl rdy wi wf addr data
    vecs[0]  = mk(1, 5, 'h1234, 0,  0, 0,  0,    0,   0, 1, 1, 0, 5,  'h1234);
    vecs[1]  = mk(0, 0, 0,      0,  0, 0,  0,    0,   0, 1, 0, 0, 0,  0);
    vecs[2]  = mk(0, 0, 0,      0,  1, 7,  'hAA, 1,   0, 0, 0, 0, 0,  0);
    vecs[3]  = mk(0, 0, 0,      0,  0, 0,  0,    0,   0, 1, 0, 1, 7,  'hAA);
    vecs[4]  = mk(1, 0, 'h55,   0,  0, 0,  0,    0,   0, 1, 0, 0, 0,  0);
    vecs[5]  = mk(0, 0, 0,      0,  1, 0,  'h77, 1,   0, 0, 0, 0, 0,  0);
    vecs[6]  = mk(0, 0, 0,      0,  0, 0,  0,    0,   0, 1, 0, 1, 0,  'h77);
    vecs[7]  = mk(1, 0, 'h66,   1,  0, 0,  0,    0,   0, 1, 0, 1, 0,  'h66);
    vecs[8]  = mk(0, 0, 0,      0,  1, 9,  'hBB, 0,   0, 0, 0, 0, 0,  0);
    vecs[9]  = mk(1, 9, 'hCC,   0,  0, 0,  0,    0,   0, 1, 1, 0, 9,  'hCC);
    vecs[10] = mk(0, 0, 0,      0,  0, 0,  0,    0,   0, 1, 0, 0, 0,  0);
    vecs[11] = mk(0, 0, 0,      0,  1, 3,  'h33, 0,   0, 0, 0, 0, 0,  0);
    vecs[12] = mk(1, 3, 'h44,   1,  0, 0,  0,    0,   0, 0, 0, 1, 3,  'h44);
    vecs[13] = mk(0, 0, 0,      0,  0, 0,  0,    0,   0, 1, 1, 0, 3,  'h33);
    vecs[14] = mk(1, 1, 'h01,   0,  1, 10, 'hD0, 0,   0, 0, 1, 0, 1,  'h01);
    vecs[15] = mk(1, 2, 'h02,   0,  0, 0,  0,    0,   0, 0, 1, 0, 2,  'h02);
    vecs[16] = mk(1, 3, 'h03,   0,  0, 0,  0,    0,   0, 0, 1, 0, 3,  'h03);
    vecs[17] = mk(1, 4, 'h04,   0,  0, 0,  0,    0,   0, 0, 1, 0, 4,  'h04);
    vecs[18] = mk(1, 10, 'hE0,  0,  0, 0,  0,    0,   0, 1, 1, 0, 10, 'hE0);
    vecs[19] = mk(0, 0, 0,      0,  0, 0,  0,    0,   0, 1, 0, 0, 0,  0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].pwe, vecs[i].prd, vecs[i].pdata, vecs[i].pfp,
            vecs[i].lv, vecs[i].lrd, vecs[i].ldata, vecs[i].lfp);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].es, vecs[i].er, vecs[i].ewi,
              vecs[i].ewf, vecs[i].ea, vecs[i].ed);
    end

    // Starvation: capture with the pipe busy, four granted pipe cycles, then FORCE.
    for (int k = 0; k < 5; k++) begin
      drive(1, 11, 'h100 + k, 0, (k == 0) ? 1 : 0, 12, 'hF00, 0);
      step();
      chk_out($sformatf("starve_c%0d", k), (k == 4) ? 1 : 0, 0, 1, 0, 11, 'h100 + k);
    end
    drive(1, 11, 'h105, 0, 0, 0, 0, 0);
    step();
    chk_out("starve_drain", 0, 1, 1, 0, 12, 'hF00);
    step();
    chk_out("starve_replay", 0, 1, 1, 0, 11, 'h105);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_out("starve_idle", 0, 1, 0, 0, 0, 0);

    // Asynchronous reset while in FORCE discards the buffered result.
    for (int k = 0; k < 5; k++) begin
      drive(1, 13, 'h200 + k, 0, (k == 0) ? 1 : 0, 14, 'hF11, 1);
      step();
    end
    chk_out("pre_reset_force", 1, 0, 1, 0, 13, 'h204);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("post_reset%0d", k), 0, 1, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
